// File: rtl/sc_pointdowncounter.sv
// -----------------------------------------------------------------------------
// sc_pointdowncounter
//
// Loadable, saturating down counter that consumes points (lives, remaining
// moves, ...) one per request. Each falling edge of the active-low request
// strobe removes one point. When the count reaches zero, the block raises a
// level flag. A decrement that takes the count from 1 to 0 also produces a
// one-cycle expiry pulse.
//
// Optional feature, controlled by the macro SC_POINTDOWNCOUNTER_AUTORELOAD_EN:
//   defined   : at the edge after an expiry, the count reloads INITVALUE.
//               A load or reset in that cycle takes priority.
//   undefined : the EMPTY state is held until a load or reset.
//
// Parameters
//   POINTDOWNCOUNTER_DATAWIDTH  width of the count and load buses
//   POINTDOWNCOUNTER_INITVALUE  value taken on reset (and on auto-reload)
//
// Ports
//   SC_POINTDOWNCOUNTER_CLOCK_50        in   system clock, rising edge
//   SC_POINTDOWNCOUNTER_RESET_InHigh    in   synchronous active-high reset
//   SC_POINTDOWNCOUNTER_load_InLow      in   active-low load strobe
//   SC_POINTDOWNCOUNTER_data_InBUS      in   load value
//   SC_POINTDOWNCOUNTER_downcount_InLow in   active-low decrement request
//                                            (edge detected)
//   SC_POINTDOWNCOUNTER_data_OutBUS     out  current count (registered)
//   SC_POINTDOWNCOUNTER_zero_OutHigh    out  high while count == 0
//   SC_POINTDOWNCOUNTER_expired_OutHigh out  one-cycle pulse on 1 -> 0
// -----------------------------------------------------------------------------
module sc_pointdowncounter #(
    parameter int unsigned POINTDOWNCOUNTER_DATAWIDTH = 8,
    parameter logic [POINTDOWNCOUNTER_DATAWIDTH-1:0] POINTDOWNCOUNTER_INITVALUE = 8'd9
) (
    input  logic                                  SC_POINTDOWNCOUNTER_CLOCK_50,
    input  logic                                  SC_POINTDOWNCOUNTER_RESET_InHigh,
    input  logic                                  SC_POINTDOWNCOUNTER_load_InLow,
    input  logic [POINTDOWNCOUNTER_DATAWIDTH-1:0] SC_POINTDOWNCOUNTER_data_InBUS,
    input  logic                                  SC_POINTDOWNCOUNTER_downcount_InLow,
    output logic [POINTDOWNCOUNTER_DATAWIDTH-1:0] SC_POINTDOWNCOUNTER_data_OutBUS,
    output logic                                  SC_POINTDOWNCOUNTER_zero_OutHigh,
    output logic                                  SC_POINTDOWNCOUNTER_expired_OutHigh
);

    localparam int unsigned DW = POINTDOWNCOUNTER_DATAWIDTH;
    localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_EMPTY = 1'b1
    } state_t;

    localparam state_t INIT_STATE =
        (POINTDOWNCOUNTER_INITVALUE != '0) ? ST_RUN : ST_EMPTY;

    state_t         state_q, state_d;
    logic [DW-1:0]  count_q, count_d;
    logic           expired_q, expired_d;
    logic           hist_q, hist_d;
    logic           armed_q, armed_d;
    logic           dec_event;

    // The history flop resets to 1 so it reads as "inactive". On its own,
    // that would turn a request still held low across reset into a falling
    // edge. armed_q holds off edge detection until the request has been
    // seen high at or after the reset edge. After that, it stays set.
    assign dec_event = ~SC_POINTDOWNCOUNTER_downcount_InLow & hist_q & armed_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge SC_POINTDOWNCOUNTER_CLOCK_50) begin
        if (SC_POINTDOWNCOUNTER_RESET_InHigh) begin
            state_q   <= INIT_STATE;
            count_q   <= POINTDOWNCOUNTER_INITVALUE;
            expired_q <= 1'b0;
            hist_q    <= 1'b1;
            armed_q   <= SC_POINTDOWNCOUNTER_downcount_InLow;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            hist_q    <= hist_d;
            armed_q   <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: load > (auto-reload) > decrement event
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        // The history always follows the request, even when a load
        // discards the edge, so that edge is not replayed later.
        hist_d    = SC_POINTDOWNCOUNTER_downcount_InLow;
        armed_d   = armed_q | SC_POINTDOWNCOUNTER_downcount_InLow;

        if (!SC_POINTDOWNCOUNTER_load_InLow) begin
            count_d = SC_POINTDOWNCOUNTER_data_InBUS;
            state_d = (SC_POINTDOWNCOUNTER_data_InBUS != '0) ? ST_RUN : ST_EMPTY;
        end else begin
`ifdef SC_POINTDOWNCOUNTER_AUTORELOAD_EN
            // expired_q is set only when a decrement reaches EMPTY.
            // EMPTY entered through a load or reset therefore never reloads.
            if (expired_q) begin
                count_d = POINTDOWNCOUNTER_INITVALUE;
                state_d = INIT_STATE;
            end else
`endif
            if (dec_event) begin
                unique case (state_q)
                    ST_RUN: begin
                        count_d = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            state_d   = ST_EMPTY;
                            expired_d = 1'b1;
                        end
                    end
                    ST_EMPTY: begin
                        // Saturate at zero: no wrap and no expiry pulse.
                        count_d = count_q;
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SC_POINTDOWNCOUNTER_data_OutBUS     = count_q;
    assign SC_POINTDOWNCOUNTER_zero_OutHigh    = (count_q == '0);
    assign SC_POINTDOWNCOUNTER_expired_OutHigh = expired_q;

endmodule

// File: tb/tb_sc_pointdowncounter.sv
module tb_sc_pointdowncounter;

    localparam int DW   = 8;
    localparam int INIT = 9;

    logic          clk;
    logic          rst;
    logic          load_n;
    logic [DW-1:0] data_in;
    logic          req_n;
    logic [DW-1:0] data_out;
    logic          zero_out;
    logic          expired_out;

    sc_pointdowncounter dut (
        .SC_POINTDOWNCOUNTER_CLOCK_50        (clk),
        .SC_POINTDOWNCOUNTER_RESET_InHigh    (rst),
        .SC_POINTDOWNCOUNTER_load_InLow      (load_n),
        .SC_POINTDOWNCOUNTER_data_InBUS      (data_in),
        .SC_POINTDOWNCOUNTER_downcount_InLow (req_n),
        .SC_POINTDOWNCOUNTER_data_OutBUS     (data_out),
        .SC_POINTDOWNCOUNTER_zero_OutHigh    (zero_out),
        .SC_POINTDOWNCOUNTER_expired_OutHigh (expired_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] cnt;
        logic          zero;
        logic          exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model, described in terms of points and requests
    int   m_points;
    bit   m_last_req_high;  // request level last seen (reset included)
    bit   m_just_expired;
    bit   m_valid;          // model is defined once a reset has happened

`ifdef SC_POINTDOWNCOUNTER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    function automatic void model_step(bit r, bit ld_n, int d, bit rq_n);
        bit falling;
        bit was_expired;
        exp_t e;
        falling = (rq_n == 1'b0) && m_last_req_high;
        if (r) begin
            m_points        = INIT;
            m_just_expired  = 1'b0;
            m_valid         = 1'b1;
        end else begin
            was_expired    = m_just_expired;
            m_just_expired = 1'b0;
            if (ld_n == 1'b0) begin
                m_points = d;
            end else if (AUTO && was_expired) begin
                m_points = INIT;
            end else if (falling && m_points > 0) begin
                m_points = m_points - 1;
                if (m_points == 0) m_just_expired = 1'b1;
            end
        end
        m_last_req_high = rq_n;
        if (m_valid) begin
            e.cnt  = m_points[DW-1:0];
            e.zero = (m_points == 0);
            e.exp  = m_just_expired;
            sb.push_back(e);
        end
    endfunction

    // Drive one cycle of stimulus at the falling edge and record expectation
    task automatic step(input bit r, input bit ld_n, input int d, input bit rq_n);
        @(negedge clk);
        rst     = r;
        load_n  = ld_n;
        data_in = d[DW-1:0];
        req_n   = rq_n;
        model_step(r, ld_n, d, rq_n);
    endtask

    // Directed constant check right after the next rising edge
    task automatic check_now(input string name, input int cnt, input bit z, input bit e);
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== cnt[DW-1:0] || zero_out !== z || expired_out !== e) begin
            errors++;
            $display("FAIL %s: got cnt=%0d zero=%0b exp=%0b, want cnt=%0d zero=%0b exp=%0b",
                     name, data_out, zero_out, expired_out, cnt, z, e);
        end
    endtask

    // Monitor: compares the DUT against the scoreboard every cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (data_out !== e.cnt || zero_out !== e.zero || expired_out !== e.exp) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got cnt=%0d zero=%0b exp=%0b, want cnt=%0d zero=%0b exp=%0b",
                             $time, data_out, zero_out, expired_out, e.cnt, e.zero, e.exp);
                end
            end
        end
    end

    initial begin
        int d;
        bit rq;
        m_points        = 0;
        m_last_req_high = 1'b1;
        m_just_expired  = 1'b0;
        m_valid         = 1'b0;
        rst = 1'b0; load_n = 1'b1; data_in = '0; req_n = 1'b1;

        // Reset for two cycles with the request high
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        check_now("reset", 9, 0, 0);
        step(0, 1, 0, 1);

        // Request held low for five cycles: exactly one decrement
        step(0, 1, 0, 0);
        check_now("first_low", 8, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        check_now("held_low", 8, 0, 0);
        step(0, 1, 0, 1);

        // Expiry: load 2, then two separated pulses
        step(0, 0, 2, 1);
        check_now("load2", 2, 0, 0);
        step(0, 1, 0, 0);
        check_now("dec_to_1", 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check_now("expiry", 0, 1, 1);
        step(0, 1, 0, 1);
        if (AUTO) check_now("after_expiry", 9, 0, 0);
        else      check_now("after_expiry", 0, 1, 0);
        step(0, 1, 0, 0);
        if (AUTO) check_now("third_pulse", 8, 0, 0);
        else      check_now("third_pulse", 0, 1, 0);
        step(0, 1, 0, 1);

        // Load priority over a simultaneous falling edge
        step(0, 0, 5, 0);
        check_now("load_prio", 5, 0, 0);
        step(0, 1, 0, 0);
        check_now("load_release", 5, 0, 0);
        step(0, 1, 0, 1);

        // Load of 0 and of all-ones
        step(0, 0, 0, 1);
        check_now("load0", 0, 1, 0);
        step(0, 0, 255, 1);
        step(0, 1, 0, 0);
        check_now("ff_dec", 254, 0, 0);
        step(0, 1, 0, 1);

        // Reset mid-operation with the request low
        step(0, 0, 3, 0);
        check_now("load3", 3, 0, 0);
        step(1, 1, 0, 0);
        check_now("mid_reset", 9, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check_now("held_after_reset", 9, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        check_now("new_edge", 8, 0, 0);

        // Randomized traffic
        rq = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rq = ~rq;
            case ($urandom_range(0, 7))
                0:       d = 255;
                1:       d = $urandom_range(0, 255);
                default: d = $urandom_range(0, 3);
            endcase
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 11) != 0),
                 d, rq);
        end

        step(0, 1, 0, 1);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_pointdowncounter.md
# sc_pointdowncounter

Loadable, saturating down counter that consumes points, for example lives or remaining moves, one per request. It is the decrementing counterpart of the point up-counter. Each falling edge on an active-low request strobe removes exactly one point. When the count reaches zero the block raises a level flag and a one-cycle expiry pulse, which the game controller uses to end a round or to trigger a reload.

## Interface
- POINTDOWNCOUNTER_DATAWIDTH, default 8: width of the count and load buses.
- POINTDOWNCOUNTER_INITVALUE, default 8'd9: value taken on reset (and on auto-reload, see Configuration).

Ports:
- SC_POINTDOWNCOUNTER_CLOCK_50, input, 1 bit: single system clock; all state changes occur on its rising edge.
- SC_POINTDOWNCOUNTER_RESET_InHigh, input, 1 bit: reset, synchronous and active-high.
- SC_POINTDOWNCOUNTER_load_InLow, input, 1 bit: active-low load; count takes data_InBUS.
- SC_POINTDOWNCOUNTER_data_InBUS, input, DATAWIDTH bits: load value.
- SC_POINTDOWNCOUNTER_downcount_InLow, input, 1 bit: active-low decrement request, edge-detected.
- SC_POINTDOWNCOUNTER_data_OutBUS, output, DATAWIDTH bits: current count (registered).
- SC_POINTDOWNCOUNTER_zero_OutHigh, output, 1 bit: high while the count equals 0.
- SC_POINTDOWNCOUNTER_expired_OutHigh, output, 1 bit: one-cycle pulse when a decrement takes the count from 1 to 0.

## Operation
- **State machine:**
  - RUN: count > 0.
  - EMPTY: count == 0.
- **Reset** (sampled high at a rising edge):
  - count = INITVALUE; state = RUN if INITVALUE != 0, otherwise EMPTY.
  - zero = (INITVALUE == 0); expired = 0.
  - Request history register = 1, so it reads as inactive.
- **Request edge detection:**
  - A history flop holds the previous sampled value of downcount_InLow.
  - A decrement event is: current sample == 0 AND history == 1.
  - Holding the request low yields exactly one event.
  - A new event requires the request to return high for at least one sampled cycle.
- **Priority** (highest first): reset, load, decrement event.
- **Load** (load_InLow == 0):
  - count = data_InBUS; state = RUN if the value is nonzero, otherwise EMPTY.
  - expired is not pulsed.
  - A decrement event in the same cycle is discarded.
  - The history flop still updates, so the discarded edge is not replayed.
- **Decrement event in RUN:**
  - count = count - 1.
  - If the old count == 1: state becomes EMPTY and expired pulses high for one cycle.
- **Decrement event in EMPTY:** ignored. The count saturates at 0, no wrap to all-ones, and expired is not pulsed.
- **Arithmetic:**
  - Unsigned, DATAWIDTH bits. No borrow output.
  - Load accepts any value, including all-ones.
- **Outputs:**
  - zero_OutHigh is decoded from the count register.
  - expired_OutHigh is a registered pulse.

## Timing
- **Load:** sampled at edge k; data_OutBUS shows the new value after edge k (1 cycle).
- **Decrement:** request first sampled low at edge k with history high; count updates after edge k.
- **Expiry:** zero and expired rise together after the same edge, k.
- **expired_OutHigh:** high for exactly one clock, then low at edge k+1.
- **Reset:**
  - Synchronous: the count does not change until a rising edge samples reset high.
  - Reset mid-operation discards any pending edge.
  - If the request is already low when reset is released, no decrement happens until the request goes high and then low again.

## Configuration
- **Macro:** SC_POINTDOWNCOUNTER_AUTORELOAD_EN.
- **Defined:**
  - At the edge after an expiry (state EMPTY reached by decrement), the count reloads INITVALUE and the state returns to RUN, or stays EMPTY if INITVALUE == 0.
  - zero is high for exactly one cycle.
  - A load or reset in that cycle has priority over the auto-reload.
  - Entering EMPTY through load or reset does not auto-reload.
- **Undefined:** EMPTY is held until a load or reset.

## Test plan
- **Reset:** reset high for 2 cycles, request high → data_OutBUS = 9, zero = 0, expired = 0.
- **Single edge, held low:** from 9, request held low for 5 cycles → count 8 one cycle after the first low sample, unchanged afterwards.
- **Expiry:** load 2, then two separated request pulses → counts 1, 0. zero rises with the second decrement; expired is high for exactly one cycle.
  - Macro undefined: a third pulse leaves the count at 0 with no expired pulse.
  - Macro defined: the count is 9 one cycle after the expiry.
- **Load priority:** load_InLow = 0 with data_InBUS = 8'h05 in the same cycle as a request falling edge → count = 5 (no decrement).
  - Releasing the load while the request stays low causes no decrement.
- **Load of 0 and all-ones:** load 0 → zero = 1, expired = 0. Load 8'hFF, one request pulse → 8'hFE.
- **Reset mid-operation:** at count 3 with the request low, assert reset for 1 cycle → count 9. No decrement until the request goes high and then low again.
